// File: rtl/instr_fetch_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_arb_pkg
// Brief  : Shared types and constants for the two-port instruction fetch arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package instr_fetch_arb_pkg;

  localparam int          c_NUM_PORTS = 2;
  localparam logic [31:0] c_NO_OP     = 32'h0000_0013;  // addi x0, x0, 0

  typedef logic port_id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RESP     = 2'd2
  } arb_state_e;

  function automatic port_id_t other_port(input port_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_rr_pick
// Brief  : Combinational 2-way round-robin pick; the pointed-to port wins ties.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_rr_pick
  import instr_fetch_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_t   i_ptr,
  output logic       o_valid,
  output port_id_t   o_winner
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = i_ptr;
    if (!i_req[i_ptr]) begin
      o_winner = other_port(i_ptr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_arbiter
// Brief  : Round-robin sharing of one instruction memory between two fetch
//          ports, one access in flight, grant timeout answered with NO_OP.
//          Optional per-port grant / timeout counters: INSTR_FETCH_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_arbiter
  import instr_fetch_arb_pkg::*;
#(
  parameter int NUM_PORTS   = c_NUM_PORTS,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic                              err_o,
  output logic                              mem_req_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  input  logic                              mem_gnt_i,
  input  logic [DATA_W-1:0]                 mem_rdata_i
`ifdef INSTR_FETCH_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]        gnt_cnt_o,
  output logic [31:0]                       timeout_cnt_o
`endif
);

  localparam int c_CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;

  generate
    if (NUM_PORTS != 2) begin : g_num_ports_check
      $error("instr_fetch_arbiter: NUM_PORTS must be 2");
    end
  endgenerate

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  port_id_t             r_winner;
  port_id_t             r_ptr;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic [c_CNT_W-1:0]   r_tmo_cnt;
  logic                 w_pick_valid;
  port_id_t             w_pick;
  logic                 w_expired;
  logic                 w_timeout;

  instr_fetch_rr_pick u_rr_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick)
  );

  // Counter holds the number of WAIT_GNT cycles already elapsed, so expiry
  // lands on the GNT_TIMEOUT-th cycle; a grant there still wins.
  generate
    if (GNT_TIMEOUT > 0) begin : g_timeout
      assign w_expired = (r_tmo_cnt == c_CNT_W'(GNT_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = WAIT_GNT;
      end
      WAIT_GNT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_addr;
        if (mem_gnt_i || w_expired) begin
          gnt_o[r_winner] = 1'b1;
          w_timeout       = !mem_gnt_i;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        rvalid_o[r_winner] = 1'b1;
        err_o              = r_err;
        w_state_nxt        = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_winner  <= 1'b0;
      r_ptr     <= 1'b0;
      r_addr    <= '0;
      r_rdata   <= DATA_W'(c_NO_OP);
      r_err     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_winner  <= w_pick;
            r_addr    <= addr_i[w_pick];
            r_tmo_cnt <= '0;
          end
        end
        WAIT_GNT: begin
          r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
          if (mem_gnt_i) begin
            r_rdata <= mem_rdata_i;
            r_err   <= 1'b0;
          end else if (w_expired) begin
            r_rdata <= DATA_W'(c_NO_OP);
            r_err   <= 1'b1;
          end
        end
        RESP: r_ptr <= other_port(r_winner);
        default: ;
      endcase
    end
  end

  assign rdata_o = r_rdata;

`ifdef INSTR_FETCH_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] r_gnt_cnt;
  logic [31:0]                r_timeout_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt_cnt     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_o[p] && (r_gnt_cnt[p] != 32'hFFFF_FFFF)) begin
          r_gnt_cnt[p] <= r_gnt_cnt[p] + 32'd1;
        end
      end
      if (w_timeout && (r_timeout_cnt != 32'hFFFF_FFFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 32'd1;
      end
    end
  end

  assign gnt_cnt_o     = r_gnt_cnt;
  assign timeout_cnt_o = r_timeout_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_arbiter
// Brief  : Directed and randomized checks of instr_fetch_arbiter against a
//          transaction-level model of the fetch protocol.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_arbiter;

  localparam int          c_TMO = 16;
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic             mem_gnt;
  logic [31:0]      mem_rdata;
  logic [1:0]       gnt, rvalid;
  logic [31:0]      rdata, mem_addr;
  logic             err, mem_req;
`ifdef INSTR_FETCH_ARB_STATS_EN
  logic [1:0][31:0] gnt_cnt;
  logic [31:0]      tmo_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_arbiter #(
    .NUM_PORTS   (2),
    .ADDR_W      (32),
    .DATA_W      (32),
    .GNT_TIMEOUT (c_TMO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .addr_i        (addr),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .err_o         (err),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_gnt_i     (mem_gnt),
    .mem_rdata_i   (mem_rdata)
`ifdef INSTR_FETCH_ARB_STATS_EN
    ,
    .gnt_cnt_o     (gnt_cnt),
    .timeout_cnt_o (tmo_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: an accepted fetch is in flight for m_age cycles,
  // then exactly one response cycle follows.
  bit          m_busy, m_resp, m_err, m_win, m_ptr;
  int          m_age;
  logic [31:0] m_addr, m_rdata;
  int unsigned m_gcnt [2];
  int unsigned m_tcnt;
  int          resp_log [$];

  always @(negedge clk) begin
    logic [1:0]  e_gnt, e_rv;
    logic        e_err, e_req, take;
    logic [31:0] e_addr;
    if (!rst_n) begin
      chk("reset gnt_o", 32'(gnt), 32'd0);
      chk("reset rvalid_o", 32'(rvalid), 32'd0);
      chk("reset err_o", 32'(err), 32'd0);
      chk("reset mem_req_o", 32'(mem_req), 32'd0);
      chk("reset mem_addr_o", mem_addr, 32'd0);
      chk("reset rdata_o", rdata, c_NOP);
      m_busy = 0; m_resp = 0; m_err = 0; m_win = 0; m_ptr = 0; m_age = 0;
      m_addr = '0; m_rdata = c_NOP; m_gcnt = '{0, 0}; m_tcnt = 0;
    end else begin
      e_gnt = '0; e_rv = '0; e_err = 1'b0; e_req = 1'b0; e_addr = '0; take = 1'b0;
      if (m_resp) begin
        e_rv[m_win] = 1'b1;
        e_err       = m_err;
      end else if (m_busy) begin
        e_req  = 1'b1;
        e_addr = m_addr;
        take   = mem_gnt || (m_age == c_TMO - 1);
        if (take) e_gnt[m_win] = 1'b1;
      end
      chk("gnt_o", 32'(gnt), 32'(e_gnt));
      chk("rvalid_o", 32'(rvalid), 32'(e_rv));
      chk("err_o", 32'(err), 32'(e_err));
      chk("mem_req_o", 32'(mem_req), 32'(e_req));
      chk("mem_addr_o", mem_addr, e_addr);
      chk("rdata_o", rdata, m_rdata);
      if (m_resp) begin
        resp_log.push_back(int'(m_win));
        m_ptr  = !m_win;
        m_resp = 0;
      end else if (m_busy) begin
        if (take) begin
          m_rdata = mem_gnt ? mem_rdata : c_NOP;
          m_err   = !mem_gnt;
          m_gcnt[m_win]++;
          if (!mem_gnt) m_tcnt++;
          m_busy = 0;
          m_resp = 1;
        end else begin
          m_age++;
        end
      end else if (req != 2'b00) begin
        m_win  = req[m_ptr] ? m_ptr : !m_ptr;
        m_addr = addr[m_win];
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int         n;
  bit         got;
  logic [1:0] g;
  int         gnt_pct [3] = '{80, 30, 3};
  int         req_pct [3] = '{60, 90, 50};

  initial begin
    req = '0; addr = '0; mem_gnt = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("t0 reset rdata_o literal", rdata, 32'h0000_0013);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Single request, memory always granting.
    req = 2'b01; addr[0] = 32'h8; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("t1 idle gnt_o", 32'(gnt), 32'd0);
    step();
    @(negedge clk); chk("t1 gnt_o", 32'(gnt), 32'd1); chk("t1 mem_addr_o", mem_addr, 32'h8);
    step(); req = 2'b00;
    @(negedge clk);
    chk("t1 rvalid_o", 32'(rvalid), 32'd1);
    chk("t1 rdata_o", rdata, 32'hDEAD_BEEF);
    chk("t1 err_o", 32'(err), 32'd0);
    step();
    @(negedge clk); chk("t1 rdata hold", rdata, 32'hDEAD_BEEF); chk("t1 rvalid idle", 32'(rvalid), 32'd0);

    // Grant arrives in the fifth WAIT_GNT cycle.
    step(); req = 2'b01; addr[0] = 32'h40; mem_gnt = 1'b0;
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      mem_gnt   = (k == 5);
      mem_rdata = (k == 5) ? 32'hCAFE_F00D : $urandom;
      @(negedge clk);
      if (mem_req) n++;
    end
    step(); req = 2'b00; mem_gnt = 1'b0;
    @(negedge clk);
    chk("t3 mem_req cycles", 32'(n), 32'd5);
    chk("t3 rvalid_o", 32'(rvalid), 32'd1);
    chk("t3 rdata_o", rdata, 32'hCAFE_F00D);

    // Memory never grants: timeout after 16 WAIT_GNT cycles.
    step(); req = 2'b10; addr[1] = 32'h100; mem_gnt = 1'b0;
    n = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      @(negedge clk);
      if (mem_req) n++;
      if (gnt != 2'b00) got = 1;
    end
    chk("t4 wait cycles", 32'(n), 32'd16);
    chk("t4 gnt_o", 32'(gnt), 32'd2);
    step(); req = 2'b00;
    @(negedge clk);
    chk("t4 rvalid_o", 32'(rvalid), 32'd2);
    chk("t4 rdata_o", rdata, 32'h0000_0013);
    chk("t4 err_o", 32'(err), 32'd1);
    step(); req = 2'b01; addr[0] = 32'h44; mem_gnt = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    @(negedge clk); chk("t4 next gnt_o", 32'(gnt), 32'd1);
    step(); req = 2'b00;
    @(negedge clk);
    chk("t4 next rdata_o", rdata, 32'h1234_5678);
    chk("t4 next err_o", 32'(err), 32'd0);

    // Reset while waiting for a grant, then both ports request continuously.
    step(); req = 2'b11; addr[0] = 32'h1000; addr[1] = 32'h2000; mem_gnt = 1'b0;
    step();
    @(negedge clk); chk("t5 mem_req before reset", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async mem_req_o", 32'(mem_req), 32'd0);
    chk("t5 async gnt_o", 32'(gnt), 32'd0);
    chk("t5 async rvalid_o", 32'(rvalid), 32'd0);
    step(); step();
    rst_n = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hA5A5_0001;
    resp_log.delete();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1; else step();
    end
    chk("t5 first gnt after reset", 32'(gnt), 32'd1);
    chk("t5 first mem_addr_o", mem_addr, 32'h1000);
    for (int k = 0; k < 60 && resp_log.size() < 4; k++) step();
    chk("t2 responses seen", 32'(resp_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2 response order %0d", i),
          32'(resp_log.size() > i ? resp_log[i] : -1), 32'(i % 2));
    end
    req = 2'b00;

`ifdef INSTR_FETCH_ARB_STATS_EN
    // Fresh counters: ten alternating responses plus one timeout.
    step(); rst_n = 1'b0; step(); rst_n = 1'b1;
    req = 2'b11; mem_gnt = 1'b1;
    for (int k = 0; k < 100 && (m_gcnt[0] + m_gcnt[1]) < 10; k++) step();
    req = 2'b00;
    for (int k = 0; k < 4; k++) step();
    req = 2'b01; mem_gnt = 1'b0;
    for (int k = 0; k < 40 && m_tcnt < 1; k++) step();
    req = 2'b00;
    for (int k = 0; k < 4; k++) step();
    chk("t6 timeout_cnt_o", tmo_cnt, 32'd1);
    chk("t6 gnt total", gnt_cnt[0] + gnt_cnt[1], 32'd11);
    chk("t6 gnt_cnt_o[0]", gnt_cnt[0], 32'(m_gcnt[0]));
    chk("t6 gnt_cnt_o[1]", gnt_cnt[1], 32'(m_gcnt[1]));
`endif

    // Randomized traffic with varying grant rates, including timeouts.
    for (int mode = 0; mode < 3; mode++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        g = gnt;
        step();
        for (int p = 0; p < 2; p++) begin
          if (g[p] || !req[p]) begin
            req[p] = ($urandom_range(0, 99) < req_pct[mode]);
            if (req[p]) addr[p] = $urandom & 32'hFFFF_FFFC;
          end else if ($urandom_range(0, 31) == 0) begin
            req[p] = 1'b0;
          end
        end
        mem_gnt   = ($urandom_range(0, 99) < gnt_pct[mode]);
        mem_rdata = $urandom;
      end
    end
    req = 2'b00;
    for (int k = 0; k < 40 && (m_busy || m_resp); k++) step();
    @(negedge clk);
    chk("end idle", 32'(m_busy || m_resp), 32'd0);

`ifdef INSTR_FETCH_ARB_STATS_EN
    chk("end gnt_cnt_o[0]", gnt_cnt[0], 32'(m_gcnt[0]));
    chk("end gnt_cnt_o[1]", gnt_cnt[1], 32'(m_gcnt[1]));
    chk("end timeout_cnt_o", tmo_cnt, 32'(m_tcnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
